// File: rtl/program_loader.sv
// Program loader: parses an ASCII source stream into 4-bit opcodes, writes them to
// program memory, appends a stop opcode and releases the execution controller.
module program_loader #(
    parameter int ADDR_W  = 8,
    parameter int DEPTH_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              char_valid,
    input  logic [7:0]        char_data,
    output logic              char_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_wdata,
    output logic [ADDR_W-1:0] prog_len,
    output logic              done,
    output logic              err,
    output logic [1:0]        err_code,
    output logic              cpu_reset
);

    // state  | meaning
    // IDLE   | out of reset, waiting for start
    // ACCEPT | taking source characters, one per cycle
    // WRITE  | writing the latched command opcode
    // TERM   | terminator seen: write stop or flag unmatched '['
    // DONE   | program loaded, done held until next start
    // ERROR  | load aborted, err/err_code held until next start
    typedef enum logic [2:0] {
        S_IDLE, S_ACCEPT, S_WRITE, S_TERM, S_DONE, S_ERROR
    } state_t;

    localparam logic [3:0]         OP_OPEN   = 4'b0100;
    localparam logic [3:0]         OP_CLOSE  = 4'b0101;
    localparam logic [3:0]         OP_STOP   = 4'b1111;
    localparam logic [ADDR_W-1:0]  PTR_LAST  = '1;
    localparam logic [DEPTH_W-1:0] DEPTH_MAX = '1;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [DEPTH_W-1:0] depth_q, depth_d;
    logic [3:0]         opcode_q, opcode_d;
    logic [ADDR_W-1:0]  prog_len_q, prog_len_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic [1:0]         err_code_q, err_code_d;
    logic               cpu_reset_q, cpu_reset_d;

    logic       is_cmd, is_term;
    logic [3:0] char_op;

    always_comb begin
        is_cmd  = 1'b1;
        is_term = 1'b0;
        char_op = 4'b0000;
        case (char_data)
            8'h3C: char_op = 4'b0000;
            8'h3E: char_op = 4'b0001;
            8'h2B: char_op = 4'b0010;
            8'h2D: char_op = 4'b0011;
            8'h5B: char_op = 4'b0100;
            8'h5D: char_op = 4'b0101;
            8'h2E: char_op = 4'b0110;
            8'h2C: char_op = 4'b0111;
            8'h00, 8'h21: begin
                is_cmd  = 1'b0;
                is_term = 1'b1;
            end
            default: is_cmd = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            depth_q     <= '0;
            opcode_q    <= '0;
            prog_len_q  <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            err_code_q  <= 2'b00;
            cpu_reset_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            depth_q     <= depth_d;
            opcode_q    <= opcode_d;
            prog_len_q  <= prog_len_d;
            done_q      <= done_d;
            err_q       <= err_d;
            err_code_q  <= err_code_d;
            cpu_reset_q <= cpu_reset_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        depth_d     = depth_q;
        opcode_d    = opcode_q;
        prog_len_d  = prog_len_q;
        done_d      = done_q;
        err_d       = err_q;
        err_code_d  = err_code_q;
        cpu_reset_d = 1'b0;
        char_ready  = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) begin
                    state_d    = S_ACCEPT;
                    wr_ptr_d   = '0;
                    depth_d    = '0;
                    prog_len_d = '0;
                    done_d     = 1'b0;
                    err_d      = 1'b0;
                    err_code_d = 2'b00;
                end
            end
            S_ACCEPT: begin
                char_ready = 1'b1;
                if (char_valid) begin
                    if (is_term) begin
                        state_d = S_TERM;
                    end else if (is_cmd) begin
                        // The last slot is kept free so the stop opcode always fits.
                        if (char_op == OP_CLOSE && depth_q == '0) begin
                            state_d    = S_ERROR;
                            err_d      = 1'b1;
                            err_code_d = 2'b01;
                        end else if (wr_ptr_q == PTR_LAST) begin
                            state_d    = S_ERROR;
                            err_d      = 1'b1;
                            err_code_d = 2'b10;
                        end else if (char_op == OP_OPEN && depth_q == DEPTH_MAX) begin
                            state_d    = S_ERROR;
                            err_d      = 1'b1;
                            err_code_d = 2'b11;
                        end else begin
                            opcode_d = char_op;
                            state_d  = S_WRITE;
                            if (char_op == OP_OPEN)
                                depth_d = depth_q + DEPTH_W'(1);
                            else if (char_op == OP_CLOSE)
                                depth_d = depth_q - DEPTH_W'(1);
                        end
                    end
                end
            end
            S_WRITE: begin
                mem_we    = 1'b1;
                mem_addr  = wr_ptr_q;
                mem_wdata = opcode_q;
                wr_ptr_d  = wr_ptr_q + ADDR_W'(1);
                state_d   = S_ACCEPT;
            end
            S_TERM: begin
                if (depth_q != '0) begin
                    state_d    = S_ERROR;
                    err_d      = 1'b1;
                    err_code_d = 2'b11;
                end else begin
                    mem_we      = 1'b1;
                    mem_addr    = wr_ptr_q;
                    mem_wdata   = OP_STOP;
                    prog_len_d  = wr_ptr_q;
                    done_d      = 1'b1;
                    cpu_reset_d = 1'b1;
                    state_d     = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign prog_len  = prog_len_q;
    assign done      = done_q;
    assign err       = err_q;
    assign err_code  = err_code_q;
    assign cpu_reset = cpu_reset_q;

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: directed and random source streams compared against a
// character-level model of the loading rules, plus reset and mid-stream reset checks.
module tb_program_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, start, char_valid, sel;
    logic [7:0] char_data;

    logic       char_ready_m, mem_we_m, done_m, err_m, cpu_reset_m;
    logic [7:0] mem_addr_m, prog_len_m;
    logic [3:0] mem_wdata_m;
    logic [1:0] err_code_m;

    logic       char_ready_s, mem_we_s, done_s, err_s, cpu_reset_s;
    logic [1:0] mem_addr_s, prog_len_s;
    logic [3:0] mem_wdata_s;
    logic [1:0] err_code_s;

    logic       char_ready, mem_we, done, err, cpu_reset;
    logic [7:0] mem_addr, prog_len;
    logic [3:0] mem_wdata;
    logic [1:0] err_code;

    program_loader dut_m (
        .clk(clk), .reset(reset), .start(start & ~sel), .char_valid(char_valid & ~sel),
        .char_data(char_data), .char_ready(char_ready_m), .mem_we(mem_we_m),
        .mem_addr(mem_addr_m), .mem_wdata(mem_wdata_m), .prog_len(prog_len_m),
        .done(done_m), .err(err_m), .err_code(err_code_m), .cpu_reset(cpu_reset_m)
    );

    program_loader #(.ADDR_W(2)) dut_s (
        .clk(clk), .reset(reset), .start(start & sel), .char_valid(char_valid & sel),
        .char_data(char_data), .char_ready(char_ready_s), .mem_we(mem_we_s),
        .mem_addr(mem_addr_s), .mem_wdata(mem_wdata_s), .prog_len(prog_len_s),
        .done(done_s), .err(err_s), .err_code(err_code_s), .cpu_reset(cpu_reset_s)
    );

    assign char_ready = sel ? char_ready_s : char_ready_m;
    assign mem_we     = sel ? mem_we_s : mem_we_m;
    assign mem_addr   = sel ? {6'b0, mem_addr_s} : mem_addr_m;
    assign mem_wdata  = sel ? mem_wdata_s : mem_wdata_m;
    assign prog_len   = sel ? {6'b0, prog_len_s} : prog_len_m;
    assign done       = sel ? done_s : done_m;
    assign err        = sel ? err_s : err_m;
    assign err_code   = sel ? err_code_s : err_code_m;
    assign cpu_reset  = sel ? cpu_reset_s : cpu_reset_m;

    int vectors = 0;
    int miscompares = 0;

    int wr_addr[$];
    int wr_data[$];
    int n_pulse, pulse_cyc, stop_cyc;
    bit timed_out;
    int exp_w[$];
    int exp_err;

    // '#' stands for a 0x00 terminator in these strings
    string dir_streams[5] = '{"+[->+<]!", "a+ b\n-#", "+]", "[[+]!", "++++"};

    // Loading rules applied one character at a time; exp_err 0 means a good load.
    function automatic void model(input byte s[$], input int aw);
        int depth, ptr, op;
        depth = 0; ptr = 0; exp_err = 0;
        exp_w.delete();
        foreach (s[i]) begin
            op = -1;
            case (s[i])
                "<": op = 0;
                ">": op = 1;
                "+": op = 2;
                "-": op = 3;
                "[": op = 4;
                "]": op = 5;
                ".": op = 6;
                ",": op = 7;
                default: op = -1;
            endcase
            if (s[i] == 8'h00 || s[i] == "!") begin
                if (depth != 0) exp_err = 3;
                else exp_w.push_back(15);
                return;
            end
            if (op >= 0) begin
                if (op == 5 && depth == 0) begin exp_err = 1; return; end
                if (ptr == (1 << aw) - 1) begin exp_err = 2; return; end
                if (op == 4 && depth == 255) begin exp_err = 3; return; end
                exp_w.push_back(op);
                ptr++;
                if (op == 4) depth++;
                if (op == 5) depth--;
            end
        end
    endfunction

    task automatic run(input byte s[$], input bit rnd, input int budget, input int abort_at);
        int idx;
        bit pending;
        wr_addr.delete(); wr_data.delete();
        n_pulse = 0; pulse_cyc = -1; stop_cyc = -2; timed_out = 1'b1;
        idx = 0;
        @(negedge clk); start = 1'b1; char_valid = 1'b0;
        @(negedge clk); start = 1'b0;
        for (int c = 0; c < budget; c++) begin
            if (idx < s.size()) begin
                char_data  = s[idx];
                char_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            end else begin
                char_valid = 1'b0;
            end
            pending = char_valid && char_ready;
            @(negedge clk);
            if (pending) idx++;
            if (mem_we) begin
                wr_addr.push_back(int'(mem_addr));
                wr_data.push_back(int'(mem_wdata));
                if (mem_wdata == 4'hF) stop_cyc = c;
            end
            if (cpu_reset) begin n_pulse++; pulse_cyc = c; end
            if ((abort_at > 0 && c + 1 >= abort_at) || done || err) begin
                timed_out = 1'b0;
                break;
            end
        end
        char_valid = 1'b0;
        if (abort_at == 0)
            repeat (3) begin
                @(negedge clk);
                if (cpu_reset) n_pulse++;
            end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        vectors++;
        if ({char_ready_m, mem_we_m, done_m, err_m, cpu_reset_m, err_code_m, prog_len_m,
             mem_addr_m, mem_wdata_m} !== '0) begin
            miscompares++;
            $display("FAIL reset_main: got outputs %b want all zero",
                     {char_ready_m, mem_we_m, done_m, err_m, cpu_reset_m, err_code_m,
                      prog_len_m, mem_addr_m, mem_wdata_m});
        end
        vectors++;
        if ({char_ready_s, mem_we_s, done_s, err_s, cpu_reset_s, err_code_s, prog_len_s,
             mem_addr_s, mem_wdata_s} !== '0) begin
            miscompares++;
            $display("FAIL reset_small: got outputs %b want all zero",
                     {char_ready_s, mem_we_s, done_s, err_s, cpu_reset_s, err_code_s,
                      prog_len_s, mem_addr_s, mem_wdata_s});
        end
        reset = 1'b0;
    endtask

    task automatic test_streams();
        string alpha, str;
        byte s[$];
        int aw, exp_pl;
        bit rnd, ok;
        alpha = "<>+-[].,ab \n++";
        for (int n = 0; n < 25; n++) begin
            s.delete();
            aw  = (n == 4) ? 2 : 8;
            sel = (n == 4);
            rnd = (n >= 5);
            if (n < 5) begin
                str = dir_streams[n];
                for (int i = 0; i < str.len(); i++)
                    s.push_back(str[i] == "#" ? 8'h00 : str[i]);
            end else begin
                for (int i = 0; i < int'($urandom_range(1, 40)); i++)
                    s.push_back(alpha[$urandom_range(0, alpha.len() - 1)]);
                s.push_back($urandom_range(0, 1) ? 8'h21 : 8'h00);
            end
            model(s, aw);
            run(s, rnd, 600, 0);
            ok = (exp_err == 0);
            vectors++;
            if (timed_out) begin
                miscompares++;
                $display("FAIL s%0d_timeout: no done/err within budget", n);
            end
            vectors++;
            if (wr_data.size() !== exp_w.size()) begin
                miscompares++;
                $display("FAIL s%0d_nwrites: got %0d want %0d", n, wr_data.size(), exp_w.size());
            end else begin
                foreach (exp_w[k]) begin
                    vectors++;
                    if (wr_addr[k] !== k || wr_data[k] !== exp_w[k]) begin
                        miscompares++;
                        $display("FAIL s%0d_write%0d: got %0h@%0d want %0h@%0d",
                                 n, k, wr_data[k], wr_addr[k], exp_w[k], k);
                    end
                end
            end
            vectors++;
            if ({done, err, err_code} !== {ok, ~ok, exp_err[1:0]}) begin
                miscompares++;
                $display("FAIL s%0d_status: got done=%0b err=%0b code=%0d want done=%0b err=%0b code=%0d",
                         n, done, err, err_code, ok, ~ok, exp_err);
            end
            exp_pl = ok ? exp_w.size() - 1 : 0;
            vectors++;
            if (int'(prog_len) !== exp_pl) begin
                miscompares++;
                $display("FAIL s%0d_prog_len: got %0d want %0d", n, prog_len, exp_pl);
            end
            vectors++;
            if (n_pulse !== (ok ? 1 : 0)) begin
                miscompares++;
                $display("FAIL s%0d_cpu_reset_count: got %0d want %0d", n, n_pulse, ok ? 1 : 0);
            end
            if (ok) begin
                vectors++;
                if (pulse_cyc !== stop_cyc + 1) begin
                    miscompares++;
                    $display("FAIL s%0d_cpu_reset_timing: got cycle %0d want %0d",
                             n, pulse_cyc, stop_cyc + 1);
                end
            end
            vectors++;
            if (char_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL s%0d_char_ready: got %0b want 0", n, char_ready);
            end
        end
        sel = 1'b0;
    endtask

    task automatic test_reset_mid();
        string alpha;
        byte s[$];
        alpha = "+-<>.,x";
        for (int r = 0; r < 3; r++) begin
            s.delete();
            for (int i = 0; i < 20; i++) s.push_back(alpha[$urandom_range(0, alpha.len() - 1)]);
            s.push_back(8'h21);
            run(s, 1'b1, 600, 8 + r * 3);
            reset = 1'b1;
            @(negedge clk);
            vectors++;
            if ({char_ready, mem_we, done, err, cpu_reset, err_code, prog_len, mem_addr,
                 mem_wdata} !== '0) begin
                miscompares++;
                $display("FAIL midreset%0d_outputs: got %b want all zero", r,
                         {char_ready, mem_we, done, err, cpu_reset, err_code, prog_len,
                          mem_addr, mem_wdata});
            end
            reset = 1'b0;
            model(s, 8);
            run(s, 1'b1, 600, 0);
            vectors++;
            if (timed_out || wr_data.size() !== exp_w.size() || wr_data.size() == 0) begin
                miscompares++;
                $display("FAIL midreset%0d_reload_writes: got %0d want %0d", r,
                         wr_data.size(), exp_w.size());
            end else begin
                foreach (exp_w[k]) begin
                    vectors++;
                    if (wr_addr[k] !== k || wr_data[k] !== exp_w[k]) begin
                        miscompares++;
                        $display("FAIL midreset%0d_write%0d: got %0h@%0d want %0h@%0d",
                                 r, k, wr_data[k], wr_addr[k], exp_w[k], k);
                    end
                end
            end
            vectors++;
            if ({done, err, int'(prog_len), n_pulse} !== {1'b1, 1'b0, exp_w.size() - 1, 1}) begin
                miscompares++;
                $display("FAIL midreset%0d_status: got done=%0b err=%0b len=%0d pulses=%0d want 1 0 %0d 1",
                         r, done, err, prog_len, n_pulse, exp_w.size() - 1);
            end
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; char_valid = 1'b0; char_data = 8'h00; sel = 1'b0;
        test_reset();
        test_streams();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, program memory address width (2^ADDR_W opcode slots).
REQ-002 SHALL have parameter DEPTH_W, default 8, bracket-depth counter width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  one clock; reset is synchronous and active-high.
REQ-005 SHALL have port start  input  1  begin a new program load.
REQ-006 SHALL have port char_valid  input  1  char_data holds a source character.
REQ-007 SHALL have port char_data  input  8  ASCII source character.
REQ-008 SHALL have port char_ready  output  1  loader accepts char_data this cycle.
REQ-009 SHALL have port mem_we  output  1  program memory write strobe.
REQ-010 SHALL have port mem_addr  output  ADDR_W  program memory write address.
REQ-011 SHALL have port mem_wdata  output  4  opcode written to program memory.
REQ-012 SHALL have port prog_len  output  ADDR_W  number of command opcodes stored, excluding stop.
REQ-013 SHALL have port done  output  1  level: valid program loaded.
REQ-014 SHALL have port err  output  1  level: load aborted.
REQ-015 SHALL have port err_code  output  2  01 unmatched ']', 10 overflow, 11 unmatched '['.
REQ-016 SHALL have port cpu_reset  output  1  one-cycle pulse releasing the execution controller.

Function
REQ-017 SHALL map characters to opcodes: '<'=0000, '>'=0001, '+'=0010, '-'=0011, '['=0100, ']'=0101, '.'=0110, ','=0111, stop=1111.
REQ-018 SHALL treat 0x00 and '!' as terminators; all other characters are comments, consumed and discarded.
REQ-019 SHALL implement states IDLE, ACCEPT, WRITE, TERM, DONE, ERROR.
REQ-020 SHALL in IDLE, DONE, ERROR drive char_ready=0 and move to ACCEPT on start=1, clearing write pointer, depth, prog_len, done, err, err_code.
REQ-021 SHALL ignore start in ACCEPT, WRITE, TERM.
REQ-022 SHALL in ACCEPT drive char_ready=1; transfer occurs only when char_valid and char_ready are both 1.
REQ-023 SHALL, on a comment transfer, stay in ACCEPT (one character per cycle).
REQ-024 SHALL, on a command transfer, latch the opcode and go to WRITE; char_ready=0 in WRITE (commands accepted at most every 2 cycles).
REQ-025 SHALL in WRITE assert mem_we=1 for exactly one cycle with mem_addr=write pointer and mem_wdata=latched opcode, then increment the pointer and return to ACCEPT.
REQ-026 SHALL increment depth on '[' and decrement on ']' at transfer time.
REQ-027 SHALL, on ']' with depth=0, write nothing and enter ERROR with err_code=01.
REQ-028 SHALL, on a command transfer with write pointer = 2^ADDR_W-1 (last slot reserved for stop), write nothing and enter ERROR with err_code=10.
REQ-029 SHALL, on a terminator transfer, go to TERM.
REQ-030 SHALL in TERM: if depth!=0, write nothing and enter ERROR with err_code=11; else assert mem_we=1, mem_addr=write pointer, mem_wdata=1111, set prog_len=write pointer, pulse cpu_reset, enter DONE.
REQ-031 SHALL hold done=1 in DONE and err=1 with err_code stable in ERROR until the next start.
REQ-032 SHALL assert cpu_reset only in the single cycle after the stop write; never on error.
REQ-033 SHALL drive mem_we=0 in all states other than WRITE and successful TERM; mem_addr and mem_wdata are don't-care when mem_we=0.
REQ-034 SHALL let depth overflow beyond 2^DEPTH_W-1 raise err_code=11 (treated as unmatched '[').

Reset
REQ-035 SHALL, on reset=1 at a rising edge, enter IDLE regardless of state, abandoning any partial load.
REQ-036 SHALL reset char_ready, mem_we, done, err, cpu_reset to 0, err_code, prog_len, write pointer and depth to 0; mem_addr=0, mem_wdata=0.

Verification
REQ-037 SHALL cover: start, stream "+[->+<]!" -> writes 0010,0100,0011,0001,0010,0000,0101 at addr 0-6, 1111 at 7, prog_len=7, done=1, one cpu_reset pulse.
REQ-038 SHALL cover: stream "a+ b\n-" then 0x00 -> only 0010@0, 0011@1, 1111@2; comments produce no mem_we; prog_len=2.
REQ-039 SHALL cover: stream "+]" -> one write (0010@0), err=1, err_code=01, no cpu_reset, char_ready=0.
REQ-040 SHALL cover: stream "[[+]!" -> err_code=11, no stop write; and ADDR_W=2, stream "++++" -> three writes then err_code=10.
REQ-041 SHALL cover: char_valid toggled randomly, reset asserted mid-stream -> IDLE, all outputs 0; subsequent start reloads cleanly from addr 0.
